// File: rtl/rtx_pkg.sv
// Shared ray-tracer types: scene objects, materials and sizing constants.
package rtx_pkg;

  localparam int SCENE_BUFFER_DEPTH = 8;
  localparam int MAX_BOUNCES        = 4;

  typedef struct packed {
    logic [7:0] albedo;
    logic [1:0] kind;
  } material;

  typedef struct packed {
    logic signed [15:0] center_x;
    logic signed [15:0] center_y;
    logic signed [15:0] center_z;
    logic        [15:0] radius;
    material            mat;
  } object;

  typedef enum logic [1:0] {
    L_IDLE  = 2'd0,
    L_FILL  = 2'd1,
    L_READY = 2'd2
  } load_state_e;

endpackage

// File: rtl/scene_buffer_if.sv
// Loader, frame-control and intersector-fetch signals of the scene buffer.
interface scene_buffer_if
  import rtx_pkg::*;
#(
  parameter int IDX_W = $clog2(SCENE_BUFFER_DEPTH)
) ();

  logic             load_start;
  object            load_obj;
  logic             load_valid;
  logic             load_last;
  logic             load_ready;
  logic             load_done;
  logic             load_err;
  logic             swap_req;
  logic [IDX_W-1:0] obj_idx;
  object            obj;
  logic             obj_last;
  logic             active_bank;
  logic [IDX_W:0]   num_objs;
  logic             scene_empty;

  modport master (
    output load_start, load_obj, load_valid, load_last, swap_req, obj_idx,
    input  load_ready, load_done, load_err, obj, obj_last, active_bank,
           num_objs, scene_empty
  );

  modport slave (
    input  load_start, load_obj, load_valid, load_last, swap_req, obj_idx,
    output load_ready, load_done, load_err, obj, obj_last, active_bank,
           num_objs, scene_empty
  );

endinterface

// File: rtl/scene_ram.sv
// Simple dual-port object RAM holding both banks; address is {bank, idx}.
module scene_ram
  import rtx_pkg::*;
#(
  parameter int DEPTH = SCENE_BUFFER_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic             i_wr_bank,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  object            i_wr_data,
  input  logic             i_rd_bank,
  input  logic [IDX_W-1:0] i_rd_idx,
  output object            o_rd_data
);

  object r_mem [2*DEPTH];
  object r_rd_data_p1;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[{i_wr_bank, i_wr_idx}] <= i_wr_data;
  end

  // Read register is reset so the fetch port shows a zero object out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_rd_data_p1 <= '0;
    else      r_rd_data_p1 <= r_mem[{i_rd_bank, i_rd_idx}];
  end

  assign o_rd_data = r_rd_data_p1;

endmodule

// File: rtl/scene_buffer.sv
// Double-buffered scene store: host fills the shadow bank while the intersector reads the active one.
module scene_buffer #(
  parameter int SCENE_BUFFER_DEPTH = rtx_pkg::SCENE_BUFFER_DEPTH,
  parameter int IDX_W              = $clog2(SCENE_BUFFER_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  scene_buffer_if.slave  bus
);

  import rtx_pkg::*;

  load_state_e      r_state;
  load_state_e      w_state_nxt;
  logic             r_active_bank;
  logic [IDX_W:0]   r_num_objs;
  logic [IDX_W:0]   r_shadow_cnt;
  logic [IDX_W-1:0] r_wptr;
  logic             r_load_done;
  logic             r_load_err;
  logic             r_obj_last_p1;
  logic             w_load_ready;
  logic             w_wr;
  logic             w_final;
  logic             w_swap;
  logic             w_rd_bank;
  logic [IDX_W:0]   w_rd_cnt;
  logic [IDX_W:0]   w_idx_plus1;
  object            w_rd_obj;

  assign w_wr    = (r_state == L_FILL) && bus.load_valid && !bus.load_start;
  assign w_final = w_wr && (bus.load_last || (r_wptr == IDX_W'(SCENE_BUFFER_DEPTH - 1)));
  assign w_swap  = (r_state == L_READY) && bus.swap_req;

  // A read sampled on the swap edge already sees the new bank and count.
  assign w_rd_bank   = r_active_bank ^ w_swap;
  assign w_rd_cnt    = w_swap ? r_shadow_cnt : r_num_objs;
  assign w_idx_plus1 = {1'b0, bus.obj_idx} + (IDX_W+1)'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= L_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.load_start) begin
      w_state_nxt = L_FILL;
    end else begin
      case (r_state)
        L_FILL:  if (w_final) w_state_nxt = L_READY;
        L_READY: if (w_swap)  w_state_nxt = L_IDLE;
        default: w_state_nxt = r_state;
      endcase
    end
  end

  always_comb begin
    w_load_ready = 1'b0;
    if (r_state == L_FILL) w_load_ready = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_active_bank <= 1'b0;
      r_num_objs    <= '0;
      r_shadow_cnt  <= '0;
      r_wptr        <= '0;
      r_load_done   <= 1'b0;
      r_load_err    <= 1'b0;
      r_obj_last_p1 <= 1'b1;
    end else begin
      if (w_swap) begin
        r_active_bank <= ~r_active_bank;
        r_num_objs    <= r_shadow_cnt;
      end
      if (bus.load_start) begin
        r_wptr       <= '0;
        r_shadow_cnt <= '0;
      end else begin
        if (w_wr)    r_wptr       <= r_wptr + IDX_W'(1);
        if (w_final) r_shadow_cnt <= {1'b0, r_wptr} + (IDX_W+1)'(1);
      end
      r_load_done <= w_final;
      r_load_err  <= w_final && !bus.load_last;
      // idx+1 >= count covers both the last valid index and out-of-range/empty reads.
      r_obj_last_p1 <= (w_idx_plus1 >= w_rd_cnt);
    end
  end

  scene_ram #(
    .DEPTH (SCENE_BUFFER_DEPTH),
    .IDX_W (IDX_W)
  ) u_ram (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_wr),
    .i_wr_bank (~r_active_bank),
    .i_wr_idx  (r_wptr),
    .i_wr_data (bus.load_obj),
    .i_rd_bank (w_rd_bank),
    .i_rd_idx  (bus.obj_idx),
    .o_rd_data (w_rd_obj)
  );

  assign bus.obj         = w_rd_obj;
  assign bus.obj_last    = r_obj_last_p1;
  assign bus.load_ready  = w_load_ready;
  assign bus.load_done   = r_load_done;
  assign bus.load_err    = r_load_err;
  assign bus.active_bank = r_active_bank;
  assign bus.num_objs    = r_num_objs;
  assign bus.scene_empty = (r_num_objs == '0);

endmodule

// File: tb/tb_scene_buffer.sv
// Directed bench for scene_buffer: reset, load/swap, load during tracing, overflow, simultaneous events, async reset.
module tb_scene_buffer;
  import rtx_pkg::*;

  localparam int DEPTH = 8;
  localparam int IW    = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  scene_buffer_if #(.IDX_W(IW)) bus ();

  scene_buffer #(.SCENE_BUFFER_DEPTH(DEPTH), .IDX_W(IW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic object mk_obj(input int n);
    object o;
    o.center_x   = 16'(n);
    o.center_y   = 16'(n * 3);
    o.center_z   = 16'(-n);
    o.radius     = 16'(n + 100);
    o.mat.albedo = 8'(n * 7);
    o.mat.kind   = 2'(n);
    return o;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.load_start = 1'b0;
    bus.load_obj   = '0;
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    bus.swap_req   = 1'b0;
    bus.obj_idx    = '0;
  endtask

  // Fill the shadow bank with n objects mk_obj(base+i); optionally keep reading
  // the active bank (expected objects mk_obj(rd_base + i%3)) during the fill.
  task automatic load_scene(input int n, input int base, input bit with_last,
                            input int rd_base);
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL load_ready_start got %b exp 1", bus.load_ready); end
    for (int i = 0; i < n; i++) begin
      bus.load_valid = 1'b1;
      bus.load_obj   = mk_obj(base + i);
      bus.load_last  = with_last && (i == n - 1);
      if (rd_base >= 0) bus.obj_idx = IW'(i % 3);
      tick();
      if (rd_base >= 0) begin
        checks++; if (bus.obj !== mk_obj(rd_base + i % 3)) begin errors++; $display("FAIL trace_read idx %0d got %h exp %h", i % 3, bus.obj, mk_obj(rd_base + i % 3)); end
      end
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL load_done got %b exp 1", bus.load_done); end
    checks++; if (bus.load_err !== !with_last) begin errors++; $display("FAIL load_err got %b exp %b", bus.load_err, !with_last); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL load_ready_after got %b exp 0", bus.load_ready); end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (3) tick();
    rst = 1'b1;
    checks++; if (bus.scene_empty !== 1'b1) begin errors++; $display("FAIL rst_empty got %b exp 1", bus.scene_empty); end
    checks++; if (bus.num_objs !== 4'd0) begin errors++; $display("FAIL rst_num got %0d exp 0", bus.num_objs); end
    checks++; if (bus.active_bank !== 1'b0) begin errors++; $display("FAIL rst_bank got %b exp 0", bus.active_bank); end
    checks++; if (bus.obj !== object'('0)) begin errors++; $display("FAIL rst_obj got %h exp 0", bus.obj); end
    checks++; if (bus.obj_last !== 1'b1) begin errors++; $display("FAIL rst_last got %b exp 1", bus.obj_last); end
    checks++; if ({bus.load_ready, bus.load_done, bus.load_err} !== 3'b000) begin errors++; $display("FAIL rst_load_flags got %b exp 000", {bus.load_ready, bus.load_done, bus.load_err}); end
    bus.obj_idx = '0;
    tick();
    checks++; if (bus.obj_last !== 1'b1) begin errors++; $display("FAIL empty_read_last got %b exp 1", bus.obj_last); end
  endtask

  task automatic test_load_swap();
    load_scene(3, 10, 1'b1, -1);
    tick();
    checks++; if (bus.load_done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b exp 0", bus.load_done); end
    checks++; if (bus.active_bank !== 1'b0) begin errors++; $display("FAIL bank_before_swap got %b exp 0", bus.active_bank); end
    bus.swap_req = 1'b1;
    bus.obj_idx  = 3'd0;
    tick();
    bus.swap_req = 1'b0;
    checks++; if (bus.active_bank !== 1'b1) begin errors++; $display("FAIL swap_bank got %b exp 1", bus.active_bank); end
    checks++; if (bus.num_objs !== 4'd3) begin errors++; $display("FAIL swap_num got %0d exp 3", bus.num_objs); end
    checks++; if (bus.scene_empty !== 1'b0) begin errors++; $display("FAIL swap_empty got %b exp 0", bus.scene_empty); end
    checks++; if (bus.obj !== mk_obj(10)) begin errors++; $display("FAIL read_a got %h exp %h", bus.obj, mk_obj(10)); end
    checks++; if (bus.obj_last !== 1'b0) begin errors++; $display("FAIL last_a got %b exp 0", bus.obj_last); end
    bus.obj_idx = 3'd1;
    tick();
    checks++; if (bus.obj !== mk_obj(11)) begin errors++; $display("FAIL read_b got %h exp %h", bus.obj, mk_obj(11)); end
    checks++; if (bus.obj_last !== 1'b0) begin errors++; $display("FAIL last_b got %b exp 0", bus.obj_last); end
    bus.obj_idx = 3'd2;
    tick();
    checks++; if (bus.obj !== mk_obj(12)) begin errors++; $display("FAIL read_c got %h exp %h", bus.obj, mk_obj(12)); end
    checks++; if (bus.obj_last !== 1'b1) begin errors++; $display("FAIL last_c got %b exp 1", bus.obj_last); end
    bus.obj_idx = 3'd5;
    tick();
    checks++; if (bus.obj_last !== 1'b1) begin errors++; $display("FAIL last_out_of_range got %b exp 1", bus.obj_last); end
  endtask

  task automatic test_load_during_trace();
    load_scene(2, 20, 1'b1, 10);
    bus.obj_idx = 3'd0;
    tick();
    checks++; if (bus.obj !== mk_obj(10)) begin errors++; $display("FAIL pre_swap_read got %h exp %h", bus.obj, mk_obj(10)); end
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    checks++; if (bus.active_bank !== 1'b0) begin errors++; $display("FAIL swap2_bank got %b exp 0", bus.active_bank); end
    checks++; if (bus.num_objs !== 4'd2) begin errors++; $display("FAIL swap2_num got %0d exp 2", bus.num_objs); end
    checks++; if (bus.obj !== mk_obj(20)) begin errors++; $display("FAIL read_d got %h exp %h", bus.obj, mk_obj(20)); end
    checks++; if (bus.obj_last !== 1'b0) begin errors++; $display("FAIL last_d got %b exp 0", bus.obj_last); end
    bus.obj_idx = 3'd1;
    tick();
    checks++; if (bus.obj !== mk_obj(21)) begin errors++; $display("FAIL read_e got %h exp %h", bus.obj, mk_obj(21)); end
    checks++; if (bus.obj_last !== 1'b1) begin errors++; $display("FAIL last_e got %b exp 1", bus.obj_last); end
    bus.obj_idx = 3'd2;
    tick();
    checks++; if (bus.obj_last !== 1'b1) begin errors++; $display("FAIL last_past_e got %b exp 1", bus.obj_last); end
  endtask

  task automatic test_overflow();
    load_scene(DEPTH, 30, 1'b0, -1);
    bus.load_valid = 1'b1;
    bus.load_obj   = mk_obj(99);
    tick();
    bus.load_valid = 1'b0;
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL ovf_ready got %b exp 0", bus.load_ready); end
    checks++; if ({bus.load_done, bus.load_err} !== 2'b00) begin errors++; $display("FAIL ovf_pulse_width got %b exp 00", {bus.load_done, bus.load_err}); end
    bus.swap_req = 1'b1;
    bus.obj_idx  = 3'd0;
    tick();
    bus.swap_req = 1'b0;
    checks++; if (bus.num_objs !== 4'd8) begin errors++; $display("FAIL ovf_num got %0d exp 8", bus.num_objs); end
    checks++; if (bus.obj !== mk_obj(30)) begin errors++; $display("FAIL ovf_read0 got %h exp %h", bus.obj, mk_obj(30)); end
    bus.obj_idx = 3'd6;
    tick();
    checks++; if (bus.obj_last !== 1'b0) begin errors++; $display("FAIL ovf_last6 got %b exp 0", bus.obj_last); end
    bus.obj_idx = 3'd7;
    tick();
    checks++; if (bus.obj !== mk_obj(37)) begin errors++; $display("FAIL ovf_read7 got %h exp %h", bus.obj, mk_obj(37)); end
    checks++; if (bus.obj_last !== 1'b1) begin errors++; $display("FAIL ovf_last7 got %b exp 1", bus.obj_last); end
  endtask

  task automatic test_simultaneous();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    checks++; if (bus.active_bank !== 1'b1) begin errors++; $display("FAIL idle_swap_bank got %b exp 1", bus.active_bank); end
    bus.load_start = 1'b1;
    tick();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b1;
    bus.load_obj   = mk_obj(40);
    tick();
    bus.load_valid = 1'b0;
    bus.swap_req   = 1'b1;
    tick();
    bus.swap_req   = 1'b0;
    checks++; if (bus.active_bank !== 1'b1) begin errors++; $display("FAIL fill_swap_bank got %b exp 1", bus.active_bank); end
    checks++; if (bus.num_objs !== 4'd8) begin errors++; $display("FAIL fill_swap_num got %0d exp 8", bus.num_objs); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL fill_swap_ready got %b exp 1", bus.load_ready); end
    bus.load_valid = 1'b1;
    bus.load_last  = 1'b1;
    bus.load_obj   = mk_obj(41);
    tick();
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
    checks++; if (bus.load_done !== 1'b1) begin errors++; $display("FAIL sim_done got %b exp 1", bus.load_done); end
    bus.swap_req   = 1'b1;
    bus.load_start = 1'b1;
    bus.obj_idx    = 3'd1;
    tick();
    bus.swap_req   = 1'b0;
    bus.load_start = 1'b0;
    checks++; if (bus.active_bank !== 1'b0) begin errors++; $display("FAIL sim_swap_bank got %b exp 0", bus.active_bank); end
    checks++; if (bus.num_objs !== 4'd2) begin errors++; $display("FAIL sim_swap_num got %0d exp 2", bus.num_objs); end
    checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL sim_restart_ready got %b exp 1", bus.load_ready); end
    checks++; if (bus.obj !== mk_obj(41)) begin errors++; $display("FAIL sim_read1 got %h exp %h", bus.obj, mk_obj(41)); end
    checks++; if (bus.obj_last !== 1'b1) begin errors++; $display("FAIL sim_last1 got %b exp 1", bus.obj_last); end
    bus.obj_idx = 3'd0;
    tick();
    checks++; if (bus.obj !== mk_obj(40)) begin errors++; $display("FAIL sim_read0 got %h exp %h", bus.obj, mk_obj(40)); end
    checks++; if (bus.obj_last !== 1'b0) begin errors++; $display("FAIL sim_last0 got %b exp 0", bus.obj_last); end
  endtask

  task automatic test_reset_mid();
    bus.load_valid = 1'b1;
    bus.load_obj   = mk_obj(50);
    tick();
    bus.load_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    checks++; if (bus.num_objs !== 4'd0) begin errors++; $display("FAIL async_num got %0d exp 0", bus.num_objs); end
    checks++; if (bus.active_bank !== 1'b0) begin errors++; $display("FAIL async_bank got %b exp 0", bus.active_bank); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL async_ready got %b exp 0", bus.load_ready); end
    checks++; if (bus.obj !== object'('0)) begin errors++; $display("FAIL async_obj got %h exp 0", bus.obj); end
    checks++; if (bus.obj_last !== 1'b1) begin errors++; $display("FAIL async_last got %b exp 1", bus.obj_last); end
    checks++; if (bus.scene_empty !== 1'b1) begin errors++; $display("FAIL async_empty got %b exp 1", bus.scene_empty); end
    #2;
    rst = 1'b1;
    bus.obj_idx = 3'd0;
    tick();
    checks++; if (bus.num_objs !== 4'd0) begin errors++; $display("FAIL post_rst_num got %0d exp 0", bus.num_objs); end
    checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL post_rst_ready got %b exp 0", bus.load_ready); end
    checks++; if (bus.obj_last !== 1'b1) begin errors++; $display("FAIL post_rst_last got %b exp 1", bus.obj_last); end
  endtask

  initial begin
    test_reset();
    test_load_swap();
    test_load_during_trace();
    test_overflow();
    test_simultaneous();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scene_buffer.md
# scene_buffer

Double-buffered object store answering the ray intersector's object-fetch requests (`obj_idx` → `obj`, `obj_last`). A host-side loader streams a new scene into the shadow bank while tracing reads the active bank. The frame controller swaps banks at a frame boundary. This gives tear-free scene updates without stalling the ray tracer.

## Interface
Parameters:
- `SCENE_BUFFER_DEPTH`, default from `rtx_pkg`: max objects per bank, power of two, ≥2.
- `IDX_W`, default `$clog2(SCENE_BUFFER_DEPTH)`: index width.

Ports:
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst` in 1: reset, **asynchronous and active-low**.
- `load_start` in 1: pulse; begin filling the shadow bank from index 0.
- `load_obj` in `$bits(object)`: object to write.
- `load_valid` in 1: `load_obj` is valid.
- `load_last` in 1: the current `load_obj` is the final object of the scene.
- `load_ready` out 1: shadow bank is accepting writes.
- `load_done` out 1: 1-cycle pulse; shadow scene complete.
- `load_err` out 1: 1-cycle pulse; overflow occurred and the scene was truncated.
- `swap_req` in 1: frame boundary; swap banks if a shadow scene is pending.
- `obj_idx` in `IDX_W`: read index from the intersector.
- `obj` out `$bits(object)`: object at `obj_idx`, registered.
- `obj_last` out 1: `obj` is the last object of the active scene, registered.
- `active_bank` out 1: bank currently being read.
- `num_objs` out `IDX_W+1`: object count of the active bank.
- `scene_empty` out 1: active bank holds no objects.

## Operation
- Loader FSM states: `L_IDLE`, `L_FILL`, `L_READY`.
  - `L_IDLE` + `load_start` → `L_FILL`; clears the write pointer and shadow count.
  - In `L_FILL`, a write occurs on `load_valid & load_ready`: `mem[~active_bank][wptr] <= load_obj`, then `wptr++`.
  - A write with `load_last`, or the write at `wptr == DEPTH-1`, moves to `L_READY`. Shadow count becomes `wptr+1`. `load_done` pulses.
  - Overflow case: the `DEPTH-1` write without `load_last` also pulses `load_err` in the same cycle as `load_done`.
  - `load_start` in `L_FILL` or `L_READY` restarts the fill; any pending shadow scene is discarded.
  - `L_READY` + `swap_req` toggles `active_bank`, sets `num_objs <= shadow count`, and moves to `L_IDLE`.
  - `swap_req` in `L_IDLE` or `L_FILL` is ignored; no swap occurs and no state changes.
  - `swap_req` and `load_start` in the same cycle while in `L_READY`: the swap happens, then go to `L_FILL` targeting the new shadow bank (the old active bank).
- Read path:
  - `obj <= mem[active_bank][obj_idx]`.
  - `obj_last <= (obj_idx >= num_objs-1) | scene_empty`.
  - If `obj_idx >= num_objs`, `obj` is don't-care but `obj_last` is forced to 1, so an intersector scan always terminates.
- `scene_empty = (num_objs == 0)`.
- `load_ready = (state == L_FILL)`.

## Timing
- Reset values:
  - state `L_IDLE`; `active_bank` 0; `num_objs` 0; `scene_empty` 1.
  - `obj` 0; `obj_last` 1.
  - `load_ready`, `load_done`, `load_err` all 0.
  - Memory contents are not reset.
- Read latency is 1 cycle: `obj_idx` sampled at edge N gives `obj`/`obj_last` valid after edge N. Fully pipelined, one read per cycle.
- Swap takes effect at the edge that samples `swap_req`. Reads sampled from that same edge onward use the new bank and the new count. No read ever mixes banks.
- `load_done`: asserted the cycle after the final write is accepted.
- `load_ready`: high from the cycle after `load_start` until the final write.
- A write to the shadow bank never affects the active-bank read data, including same-index accesses in the same cycle.
- Reset mid-load abandons the fill. Both banks are treated as empty; `num_objs` is 0.

## Structure
- `rtx_pkg` holds:
  - the `object` and `material` typedefs;
  - `SCENE_BUFFER_DEPTH`;
  - `MAX_BOUNCES`.
- Sub-module `scene_ram`: simple dual-port BRAM, `2*DEPTH` entries, one write port, one registered read port. The address is `{bank, idx}`.
- The FSM, counters, and `obj_last` compare live in `scene_buffer`. The compare uses `num_objs` pipelined alongside the RAM read.

## Test plan
- **Reset then read:** read `obj_idx=0` → `obj_last=1`, `scene_empty=1`, `num_objs=0`.
- **Load and swap:** load 3 objects A, B, C with `load_last` on C → `load_done` pulses 1 cycle after C. `swap_req` → `active_bank=1`, `num_objs=3`. Reading idx 0, 1, 2 returns A, B, C, with `obj_last` only on idx 2 (1-cycle latency).
- **Load during tracing:** while streaming reads of bank 1, load D, E into bank 0 → reads still return A, B, C. After the next `swap_req`, reads return D, E; `obj_last` is at idx 1.
- **Overflow:** write `DEPTH` objects with no `load_last` → `load_done` and `load_err` pulse together, and count = `DEPTH`. A further `load_valid` is not accepted (`load_ready=0`).
- **Simultaneous events:** `swap_req` in `L_FILL` → ignored. `swap_req` + `load_start` together in `L_READY` → swap happens and `load_ready=1` on the next cycle.
- **Reset mid-operation:** deassert `rst` (low) during `L_FILL`, asynchronously → outputs take reset values immediately. After release, `num_objs=0`.
